// File: rtl/ifu_pkg.sv
// Shared IFU issue-stage parameters and the queue entry type.
package ifu_pkg;

    localparam int unsigned PC_WIDTH   = 48;
    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned PC_STEP    = 4;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_skid_queue.sv
// Two-entry register queue; head is always slot0, pushed data appears at head next cycle.
module ifu_skid_queue #(
    parameter type entry_t = logic [7:0]
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] count,
    output entry_t     head
);

    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = push_data;
                    else                 slot1_d = push_data;
                    if (count_q != 2'd2) count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Slot0 keeps its stale value when the queue drains, so the head holds.
                    if (count_q == 2'd2) slot0_d = slot1_q;
                    if (count_q != 2'd0) count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        slot0_d = slot1_q;
                        slot1_d = push_data;
                    end else begin
                        slot0_d = push_data;
                        count_d = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = slot0_q;

endmodule

// File: rtl/ifu_issue_stage.sv
// Pops instructions from the ibuffer, tags them with consecutive PCs and queues them for decode.
module ifu_issue_stage
    import ifu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [PC_WIDTH-1:0]   boot_addr,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_addr,
    input  logic [INST_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    output logic                  clear_ibuffer,
    output logic                  ibu_inst_valid,
    output logic [INST_WIDTH-1:0] ibu_inst,
    output logic [PC_WIDTH-1:0]   ibu_pc,
    input  logic                  ibu_inst_ready
);

    logic                booted_q;
    logic                inflight_q;
    logic                clear_q;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    logic [1:0] count;
    logic [2:0] credit_used;
    logic       push, pop;
    ifu_entry_t head, push_entry;

    // Pre-pop occupancy plus the outstanding read: a decode pop frees no credit this cycle.
    assign credit_used  = {1'b0, count} + {2'b00, inflight_q};
    assign fifo_read_en = booted_q & ~fifo_empty & ~redirect_valid & ~clear_q
                        & (credit_used < 3'd2);

    assign ibu_inst_valid = (count != 2'd0) & ~redirect_valid;
    assign push           = inflight_q & ~redirect_valid;
    assign pop            = ibu_inst_valid & ibu_inst_ready;
    assign push_entry     = '{inst: fifo_data_out, pc: pc_q};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)  pc_d = redirect_addr;
        else if (!booted_q)  pc_d = boot_addr;
        else if (push)       pc_d = pc_q + PC_WIDTH'(PC_STEP);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            booted_q   <= 1'b0;
            inflight_q <= 1'b0;
            clear_q    <= 1'b0;
            pc_q       <= '0;
        end else begin
            booted_q   <= 1'b1;
            inflight_q <= fifo_read_en;
            clear_q    <= redirect_valid;
            pc_q       <= pc_d;
        end
    end

    ifu_skid_queue #(
        .entry_t (ifu_entry_t)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign ibu_inst      = head.inst;
    assign ibu_pc        = head.pc;
    assign clear_ibuffer = clear_q;

`ifndef SYNTHESIS
    overflow_check : assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (count == 2'd2) && !pop))
        else $error("issue queue overflow");
`endif

endmodule

// File: tb/tb_ifu_issue_stage.sv
// Randomized and directed bench for ifu_issue_stage against a transaction-level model.
module tb_ifu_issue_stage;

    logic        clock;
    logic        reset_n;
    logic [47:0] boot_addr;
    logic        redirect_valid;
    logic [47:0] redirect_addr;
    logic [31:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic        clear_ibuffer;
    logic        ibu_inst_valid;
    logic [31:0] ibu_inst;
    logic [47:0] ibu_pc;
    logic        ibu_inst_ready;

    ifu_issue_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .boot_addr      (boot_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .clear_ibuffer  (clear_ibuffer),
        .ibu_inst_valid (ibu_inst_valid),
        .ibu_inst       (ibu_inst),
        .ibu_pc         (ibu_pc),
        .ibu_inst_ready (ibu_inst_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] inst;
        logic [47:0] pc;
    } ent_t;

    int errors = 0;
    int checks = 0;

    // Environment ibuffer contents and the instructions loaded by the current test.
    logic [31:0] fifo_mem[$];
    logic [31:0] ins[$];

    // Reference model: what decode should see, in order.
    bit          m_booted, m_inflight, m_clr;
    logic [47:0] m_pc;
    ent_t        m_q[$];

    logic [47:0] del_pc[$];
    logic [31:0] del_inst[$];
    int edges, reads_seen, clears_seen, both_seen, first_valid_edge;

    task automatic cycle(input bit rdy, input bit redir, input logic [47:0] raddr);
        bit exp_rd, exp_valid, pop, push, sampled_rd;
        ent_t e;
        ibu_inst_ready = rdy;
        redirect_valid = redir;
        redirect_addr  = raddr;
        fifo_empty     = (fifo_mem.size() == 0);
        #1;
        exp_valid = (m_q.size() != 0) && !redir;
        exp_rd    = m_booted && !fifo_empty && !redir && !m_clr
                    && ((m_q.size() + int'(m_inflight)) < 2);
        checks++;
        if (ibu_inst_valid !== exp_valid) begin
            errors++;
            $display("FAIL valid @edge %0d: got %b want %b", edges, ibu_inst_valid, exp_valid);
        end
        checks++;
        if (fifo_read_en !== exp_rd) begin
            errors++;
            $display("FAIL read_en @edge %0d: got %b want %b", edges, fifo_read_en, exp_rd);
        end
        checks++;
        if (clear_ibuffer !== m_clr) begin
            errors++;
            $display("FAIL clear @edge %0d: got %b want %b", edges, clear_ibuffer, m_clr);
        end
        if (exp_valid) begin
            checks++;
            if (ibu_inst !== m_q[0].inst || ibu_pc !== m_q[0].pc) begin
                errors++;
                $display("FAIL head @edge %0d: got %h/%h want %h/%h", edges, ibu_inst, ibu_pc,
                         m_q[0].inst, m_q[0].pc);
            end
        end
        if (ibu_inst_valid === 1'b1 && first_valid_edge < 0) first_valid_edge = edges;
        if (fifo_read_en === 1'b1) reads_seen++;
        if (clear_ibuffer === 1'b1) clears_seen++;
        sampled_rd = (fifo_read_en === 1'b1);

        pop  = exp_valid && rdy;
        push = m_inflight && !redir;
        if (pop && push) both_seen++;
        if (pop) begin
            del_pc.push_back(m_q[0].pc);
            del_inst.push_back(m_q[0].inst);
            void'(m_q.pop_front());
        end
        if (push) begin
            e.inst = fifo_data_out;
            e.pc   = m_pc;
            m_q.push_back(e);
            m_pc = m_pc + 48'd4;
        end
        if (redir) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_pc       = raddr;
            m_clr      = 1'b1;
            m_booted   = 1'b1;
        end else begin
            m_clr = 1'b0;
            if (!m_booted) begin
                m_pc     = boot_addr;
                m_booted = 1'b1;
            end
            m_inflight = exp_rd;
        end

        @(posedge clock);
        edges++;
        #1;
        if (sampled_rd && fifo_mem.size() != 0) fifo_data_out = fifo_mem.pop_front();
        else fifo_data_out = $urandom();
    endtask

    task automatic clear_logs();
        del_pc.delete();
        del_inst.delete();
        reads_seen = 0;
        clears_seen = 0;
        both_seen = 0;
    endtask

    task automatic load_fifo(input int n);
        logic [31:0] v;
        ins.delete();
        for (int i = 0; i < n; i++) begin
            v = $urandom();
            fifo_mem.push_back(v);
            ins.push_back(v);
        end
    endtask

    task automatic do_reset(input logic [47:0] boot);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        ibu_inst_ready = 1'b0;
        boot_addr      = boot;
        m_booted = 1'b0;
        m_inflight = 1'b0;
        m_clr = 1'b0;
        m_pc = '0;
        m_q.delete();
        fifo_mem.delete();
        fifo_data_out = $urandom();
        first_valid_edge = -1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        edges = 0;
    endtask

    task automatic test_reset();
        reset_n        = 1'b1;
        fifo_empty     = 1'b0;
        redirect_valid = 1'b0;
        ibu_inst_ready = 1'b1;
        boot_addr      = 48'h1234;
        redirect_addr  = '0;
        fifo_data_out  = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (fifo_read_en !== 1'b0 || clear_ibuffer !== 1'b0 || ibu_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rd=%b clr=%b vld=%b want 0/0/0",
                     fifo_read_en, clear_ibuffer, ibu_inst_valid);
        end
        checks++;
        if (ibu_inst !== 32'd0 || ibu_pc !== 48'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 0/0", ibu_inst, ibu_pc);
        end
    endtask

    task automatic test_boot();
        do_reset(48'h8000_0000);
        load_fifo(3);
        clear_logs();
        repeat (12) cycle(1'b1, 1'b0, '0);
        checks++;
        if (first_valid_edge != 3) begin
            errors++;
            $display("FAIL boot_latency: got %0d want 3", first_valid_edge);
        end
        checks++;
        if (del_pc.size() != 3 || del_pc[0] !== 48'h8000_0000 || del_pc[1] !== 48'h8000_0004
            || del_pc[2] !== 48'h8000_0008) begin
            errors++;
            $display("FAIL boot_pcs: got n=%0d first=%h want 3 from 80000000",
                     del_pc.size(), (del_pc.size() != 0) ? del_pc[0] : 48'hx);
        end
        checks++;
        if (del_inst.size() != 3 || del_inst[0] !== ins[0] || del_inst[1] !== ins[1]
            || del_inst[2] !== ins[2]) begin
            errors++;
            $display("FAIL boot_insts: got n=%0d want 3 in load order", del_inst.size());
        end
    endtask

    task automatic test_backpressure();
        load_fifo(6);
        clear_logs();
        repeat (8) cycle(1'b0, 1'b0, '0);
        checks++;
        if (reads_seen != 2) begin
            errors++;
            $display("FAIL bp_reads: got %0d want 2", reads_seen);
        end
        checks++;
        if (fifo_read_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got %b want 0", fifo_read_en);
        end
        clear_logs();
        repeat (15) cycle(1'b1, 1'b0, '0);
        checks++;
        if (del_pc.size() < 4 || del_pc[0] !== 48'h8000_000C || del_inst[0] !== ins[0]
            || reads_seen == 0) begin
            errors++;
            $display("FAIL bp_drain: got n=%0d reads=%0d want >=4 from 8000000c",
                     del_pc.size(), reads_seen);
        end
    endtask

    task automatic test_redirect();
        do_reset(48'h2000);
        load_fifo(6);
        repeat (3) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 48'h1000);
        clear_logs();
        cycle(1'b0, 1'b0, '0);
        repeat (12) cycle(1'b1, 1'b0, '0);
        checks++;
        if (clears_seen != 1) begin
            errors++;
            $display("FAIL redir_clear: got %0d cycles want 1", clears_seen);
        end
        checks++;
        if (del_pc.size() == 0 || del_pc[0] !== 48'h1000 || del_inst[0] !== ins[2]) begin
            errors++;
            $display("FAIL redir_target: got n=%0d pc=%h want pc 1000 inst %h", del_pc.size(),
                     (del_pc.size() != 0) ? del_pc[0] : 48'hx, ins[2]);
        end
    endtask

    task automatic test_wrap();
        fifo_mem.delete();
        load_fifo(3);
        cycle(1'b1, 1'b1, 48'hFFFF_FFFF_FFFC);
        clear_logs();
        repeat (12) cycle(1'b1, 1'b0, '0);
        checks++;
        if (del_pc.size() < 2 || del_pc[0] !== 48'hFFFF_FFFF_FFFC || del_pc[1] !== 48'h0) begin
            errors++;
            $display("FAIL wrap: got n=%0d want fffffffffffc then 0", del_pc.size());
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        fifo_mem.delete();
        load_fifo(20);
        clear_logs();
        repeat (36) cycle(1'b1, 1'b0, '0);
        checks++;
        if (both_seen < 5) begin
            errors++;
            $display("FAIL b2b_overlap: got %0d want >=5", both_seen);
        end
        bad = 0;
        for (int i = 0; i < del_pc.size(); i++) begin
            if (i >= ins.size() || del_inst[i] !== ins[i]
                || del_pc[i] !== del_pc[0] + 48'(4 * i)) bad++;
        end
        checks++;
        if (bad != 0 || del_pc.size() < 10) begin
            errors++;
            $display("FAIL b2b_order: got n=%0d bad=%0d want >=10 bad=0", del_pc.size(), bad);
        end
    endtask

    task automatic test_random();
        bit          redir, prev_redir;
        logic [47:0] ra;
        logic [31:0] v;
        prev_redir = 1'b0;
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            if (fifo_mem.size() < 3 && $urandom_range(0, 3) != 0) begin
                v = $urandom();
                fifo_mem.push_back(v);
            end
            redir = prev_redir ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
            ra = {16'($urandom()), 32'($urandom())};
            ra[1:0] = 2'b00;
            cycle($urandom_range(0, 9) < 7, redir, ra);
            prev_redir = redir;
        end
    endtask

    task automatic test_async_reset();
        fifo_mem.delete();
        load_fifo(10);
        repeat (4) cycle(1'b1, 1'b0, '0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (fifo_read_en !== 1'b0 || clear_ibuffer !== 1'b0 || ibu_inst_valid !== 1'b0
            || ibu_inst !== 32'd0 || ibu_pc !== 48'd0) begin
            errors++;
            $display("FAIL async_reset: got rd=%b clr=%b vld=%b %h/%h want all 0",
                     fifo_read_en, clear_ibuffer, ibu_inst_valid, ibu_inst, ibu_pc);
        end
        do_reset(48'h4000);
        load_fifo(4);
        clear_logs();
        repeat (12) cycle(1'b1, 1'b0, '0);
        checks++;
        if (first_valid_edge != 3 || del_pc.size() != 4 || del_pc[0] !== 48'h4000) begin
            errors++;
            $display("FAIL reboot: got lat=%0d n=%0d want lat 3, 4 from 4000",
                     first_valid_edge, del_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
